// File: rtl/sdram_responder.sv
// sdram_responder: chip-side model of an SDR SDRAM (MT48LC16M16 style command
// bus) backed by a small on-chip 16-bit array. Used for FPGA loopback tests and
// as the memory behind controller benches.
//
// Ports
//   clk, reset_n            rising-edge clock, asynchronous active-low reset
//   sd_addr, sd_ba          multiplexed address and bank select
//   sd_cs/ras/cas/we        active-low command strobes (cs high = NOP)
//   sd_dqm                  byte masks, [1] = upper byte
//   sd_dq_in                write data from the controller
//   sd_dq_out, sd_dq_oe     read data and per-byte output enable (registered)
//   err                     sticky flags: [0] protocol, [1] timing, [2] illegal mode
//   refresh_cnt             saturating AUTO_REFRESH count
//
// Burst handshake: a burst starts on an accepted READ/WRITE and advances one
// beat per clock. A new READ/WRITE or BURST_TERMINATE ends it at that edge.
// Read beats are registered, so the controller samples beat k at edge N+CL+k.
module sdram_responder #(
  parameter int MEM_AW   = 12,
  parameter int COL_BITS = 9,
  parameter int T_RCD    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [12:0] sd_addr,
  input  logic [1:0]  sd_ba,
  input  logic        sd_cs,
  input  logic        sd_ras,
  input  logic        sd_cas,
  input  logic        sd_we,
  input  logic [1:0]  sd_dqm,
  input  logic [15:0] sd_dq_in,
  output logic [15:0] sd_dq_out,
  output logic [1:0]  sd_dq_oe,
  output logic [2:0]  err,
  output logic [15:0] refresh_cnt
);

  localparam int FULL_W = 2 + 13 + COL_BITS;
  localparam logic [7:0] TRCD_LOAD = (T_RCD > 0) ? 8'(T_RCD - 1) : 8'd0;

  typedef enum logic [2:0] {
    CMD_LOAD_MODE = 3'b000, CMD_REFRESH = 3'b001, CMD_PRECHARGE = 3'b010,
    CMD_ACTIVE    = 3'b011, CMD_WRITE   = 3'b100, CMD_READ      = 3'b101,
    CMD_BST       = 3'b110, CMD_NOP     = 3'b111
  } cmd_e;

  typedef enum logic [1:0] {BURST_IDLE, BURST_READ, BURST_WRITE} burst_e;

  // Mode register
  logic       mode_cl3;     // 0: CL=2, 1: CL=3
  logic [1:0] mode_bl;      // BL = 1 << mode_bl
  logic       single_wr;

  // Bank state
  logic [3:0]  bank_open;
  logic [12:0] bank_row [4];
  logic [7:0]  trcd_cnt [4];

  // Burst context captured at the READ/WRITE edge
  burst_e               burst_state, burst_next;
  logic [1:0]           b_bank;
  logic [12:0]          b_row;
  logic [COL_BITS-1:0]  b_col;
  logic [2:0]           b_beat;
  logic [2:0]           b_last;
  logic                 b_wait;
  logic                 b_ap;
  logic [1:0]           b_oe_mask;

  logic [15:0] mem [2**MEM_AW];

  cmd_e                cmd;
  logic                rw_ok, terminate, rd_fire, wr_fire, burst_done;
  logic [2:0]          rd_last, wr_last;
  logic [MEM_AW-1:0]   burst_addr, wr_addr;
  logic [COL_BITS-1:0] start_col;

  assign cmd       = sd_cs ? CMD_NOP : cmd_e'({sd_ras, sd_cas, sd_we});
  assign start_col = sd_addr[COL_BITS-1:0];
  assign rw_ok     = ((cmd == CMD_READ) || (cmd == CMD_WRITE)) && bank_open[sd_ba];
  assign terminate = rw_ok || (cmd == CMD_BST);

  function automatic logic [MEM_AW-1:0] addr_of(input logic [1:0] ba,
                                                input logic [12:0] row,
                                                input logic [COL_BITS-1:0] col);
    logic [FULL_W-1:0] full;
    full = {ba, row, col};
    return full[MEM_AW-1:0];
  endfunction

  // Sequential wrap inside the BL-aligned column block.
  function automatic logic [COL_BITS-1:0] beat_col(input logic [COL_BITS-1:0] col,
                                                   input logic [2:0] beat,
                                                   input logic [2:0] last);
    logic [COL_BITS-1:0] mask;
    mask = {{(COL_BITS-3){1'b0}}, last};
    return (col & ~mask) | ((col + {{(COL_BITS-3){1'b0}}, beat}) & mask);
  endfunction

  assign burst_addr = addr_of(b_bank, b_row, beat_col(b_col, b_beat, b_last));

  // Burst FSM: next state and per-edge beat strobes.
  always_comb begin
    burst_next = burst_state;
    rd_fire    = 1'b0;
    wr_fire    = 1'b0;
    burst_done = 1'b0;
    wr_addr    = burst_addr;
    case (mode_bl)
      2'd0:    rd_last = 3'd0;
      2'd1:    rd_last = 3'd1;
      2'd2:    rd_last = 3'd3;
      default: rd_last = 3'd7;
    endcase
    wr_last = single_wr ? 3'd0 : rd_last;

    if (terminate) begin
      burst_next = BURST_IDLE;
    end else begin
      case (burst_state)
        BURST_READ: begin
          if (!b_wait) begin
            rd_fire = 1'b1;
            if (b_beat == b_last) begin
              burst_done = 1'b1;
              burst_next = BURST_IDLE;
            end
          end
        end
        BURST_WRITE: begin
          wr_fire = 1'b1;
          if (b_beat == b_last) begin
            burst_done = 1'b1;
            burst_next = BURST_IDLE;
          end
        end
        default: ;
      endcase
    end

    if (rw_ok) begin
      if (cmd == CMD_READ) begin
        burst_next = BURST_READ;
      end else begin
        // Beat 0 of a write lands at the command edge itself.
        wr_fire    = 1'b1;
        wr_addr    = addr_of(sd_ba, bank_row[sd_ba], start_col);
        burst_next = (wr_last == 3'd0) ? BURST_IDLE : BURST_WRITE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) burst_state <= BURST_IDLE;
    else          burst_state <= burst_next;
  end

  // Array: no reset, contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      if (!sd_dqm[0]) mem[wr_addr][7:0]  <= sd_dq_in[7:0];
      if (!sd_dqm[1]) mem[wr_addr][15:8] <= sd_dq_in[15:8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sd_dq_out   <= '0;
      sd_dq_oe    <= '0;
      err         <= '0;
      refresh_cnt <= '0;
      mode_cl3    <= 1'b0;
      mode_bl     <= 2'd0;
      single_wr   <= 1'b1;
      bank_open   <= '0;
      for (int i = 0; i < 4; i++) begin
        bank_row[i] <= '0;
        trcd_cnt[i] <= '0;
      end
      b_bank    <= '0;
      b_row     <= '0;
      b_col     <= '0;
      b_beat    <= '0;
      b_last    <= '0;
      b_wait    <= 1'b0;
      b_ap      <= 1'b0;
      b_oe_mask <= '0;
    end else begin
      // Output enable is a one-cycle pulse per beat.
      sd_dq_oe <= '0;
      if (rd_fire) begin
        sd_dq_out <= mem[burst_addr];
        sd_dq_oe  <= b_oe_mask;
      end
      if (burst_state == BURST_READ && !terminate && b_wait) b_wait <= 1'b0;
      if (rd_fire || wr_fire) b_beat <= b_beat + 3'd1;
      for (int i = 0; i < 4; i++)
        if (trcd_cnt[i] != 8'd0) trcd_cnt[i] <= trcd_cnt[i] - 8'd1;
      if (burst_done && b_ap) bank_open[b_bank] <= 1'b0;

      case (cmd)
        CMD_LOAD_MODE: begin
          if (|bank_open) err[0] <= 1'b1;
          else if ((sd_addr[6:4] != 3'd2 && sd_addr[6:4] != 3'd3) || sd_addr[2]) err[2] <= 1'b1;
          else begin
            mode_cl3  <= sd_addr[4];
            mode_bl   <= sd_addr[1:0];
            single_wr <= sd_addr[9];
          end
        end
        CMD_ACTIVE: begin
          if (bank_open[sd_ba]) err[0] <= 1'b1;
          bank_open[sd_ba] <= 1'b1;
          bank_row[sd_ba]  <= sd_addr;
          trcd_cnt[sd_ba]  <= TRCD_LOAD;
        end
        CMD_PRECHARGE: begin
          if (sd_addr[10]) bank_open <= '0;
          else             bank_open[sd_ba] <= 1'b0;
        end
        CMD_REFRESH: begin
          if (refresh_cnt != 16'hFFFF) refresh_cnt <= refresh_cnt + 16'd1;
          if (|bank_open) err[0] <= 1'b1;
        end
        CMD_READ, CMD_WRITE: begin
          if (!bank_open[sd_ba]) begin
            err[0] <= 1'b1;
          end else begin
            // A nonzero counter means fewer than T_RCD edges since ACTIVE.
            if (trcd_cnt[sd_ba] != 8'd0) err[1] <= 1'b1;
            b_bank <= sd_ba;
            b_row  <= bank_row[sd_ba];
            b_col  <= start_col;
            b_ap   <= sd_addr[10];
            if (cmd == CMD_READ) begin
              b_last    <= rd_last;
              b_beat    <= 3'd0;
              b_wait    <= mode_cl3;
              b_oe_mask <= ~sd_dqm;
            end else begin
              b_last <= wr_last;
              b_beat <= 3'd1;
              if (wr_last == 3'd0 && sd_addr[10]) bank_open[sd_ba] <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder. Stimulus tasks push the expected read
// beats {sample_edge, oe, data} into exp_q; the monitor pops one entry for
// every cycle the DUT drives a nonzero output enable.
module tb_sdram_responder;

  localparam int W = 50;
  localparam logic [2:0] C_LMR = 3'b000, C_REF = 3'b001, C_PRE = 3'b010,
                         C_ACT = 3'b011, C_WR  = 3'b100, C_RD  = 3'b101,
                         C_BST = 3'b110, C_NOP = 3'b111;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [12:0] sd_addr;
  logic [1:0]  sd_ba;
  logic        sd_cs, sd_ras, sd_cas, sd_we;
  logic [1:0]  sd_dqm;
  logic [15:0] sd_dq_in;
  logic [15:0] sd_dq_out;
  logic [1:0]  sd_dq_oe;
  logic [2:0]  err;
  logic [15:0] refresh_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [W-1:0] exp_q[$];

  sdram_responder #(.MEM_AW(12), .COL_BITS(9), .T_RCD(2)) dut (
    .clk(clk), .reset_n(reset_n), .sd_addr(sd_addr), .sd_ba(sd_ba),
    .sd_cs(sd_cs), .sd_ras(sd_ras), .sd_cas(sd_cas), .sd_we(sd_we),
    .sd_dqm(sd_dqm), .sd_dq_in(sd_dq_in), .sd_dq_out(sd_dq_out),
    .sd_dq_oe(sd_dq_oe), .err(err), .refresh_cnt(refresh_cnt)
  );

  // Clock and edge counter: cyc holds the index of the most recent rising edge.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: a beat registered at edge E is sampled by the controller at E+1.
  always @(negedge clk) begin
    if (reset_n && sd_dq_oe != 2'b00) begin
      logic [W-1:0] got, e;
      logic [31:0]  se;
      se  = 32'(cyc + 1);
      got = {se, sd_dq_oe, sd_dq_out};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_unexpected: edge %0d oe=%b data=%h, required no output", se, sd_dq_oe, sd_dq_out);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_bad++;
          $display("FAIL rd_beat: got edge %0d oe=%b data=%h, required edge %0d oe=%b data=%h",
                   got[49:18], got[17:16], got[15:0], e[49:18], e[17:16], e[15:0]);
        end
      end
    end
  end

  // Driver: one command per rising edge; edge_n is the edge that samples it.
  task automatic issue(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] addr,
                       input logic [1:0] dqm, input logic [15:0] dq, output int edge_n);
    @(negedge clk);
    sd_cs = 1'b0;
    {sd_ras, sd_cas, sd_we} = c;
    sd_ba = ba; sd_addr = addr; sd_dqm = dqm; sd_dq_in = dq;
    edge_n = cyc + 1;
    @(posedge clk); #1;
    sd_cs = 1'b1;
    {sd_ras, sd_cas, sd_we} = C_NOP;
    sd_dqm = 2'b00; sd_dq_in = 16'h0000;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_rd(input int sample_edge, input logic [1:0] oe, input logic [15:0] d);
    logic [31:0] se;
    se = 32'(sample_edge);
    exp_q.push_back({se, oe, d});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    sd_cs = 1'b1; {sd_ras, sd_cas, sd_we} = C_NOP;
    sd_ba = '0; sd_addr = '0; sd_dqm = '0; sd_dq_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    idle(1);
    check("rst_oe", 32'(sd_dq_oe), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_refresh", 32'(refresh_cnt), 32'h0);
    check("rst_dq_out", 32'(sd_dq_out), 32'h0);

    // Reset mode is CL2, BL1: one beat sampled two edges after READ.
    issue(C_ACT, 2'd0, 13'h000, 2'b00, 16'h0, n); idle(1);
    issue(C_WR,  2'd0, 13'h000, 2'b00, 16'h1357, n);
    issue(C_RD,  2'd0, 13'h000, 2'b00, 16'h0, n);
    push_rd(n + 2, 2'b11, 16'h1357);
    idle(4);

    // Precharge, two refreshes, single-write CL2 BL1.
    issue(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0, n);
    issue(C_REF, 2'd0, 13'h000, 2'b00, 16'h0, n);
    issue(C_REF, 2'd0, 13'h000, 2'b00, 16'h0, n);
    issue(C_LMR, 2'd0, 13'h220, 2'b00, 16'h0, n);
    check("refresh_cnt_2", 32'(refresh_cnt), 32'd2);
    check("init_err", 32'(err), 32'h0);

    // WRITE exactly T_RCD edges after ACTIVE, then CL2 read.
    issue(C_ACT, 2'd1, 13'h012, 2'b00, 16'h0, n); idle(1);
    issue(C_WR,  2'd1, 13'h005, 2'b00, 16'hA55A, n);
    issue(C_RD,  2'd1, 13'h005, 2'b00, 16'h0, n);
    push_rd(n + 2, 2'b11, 16'hA55A);
    idle(4);
    check("trcd_boundary_err", 32'(err), 32'h0);

    // CL3: same read now sampled three edges later.
    issue(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0, n);
    issue(C_LMR, 2'd0, 13'h230, 2'b00, 16'h0, n);
    issue(C_ACT, 2'd1, 13'h012, 2'b00, 16'h0, n); idle(1);
    issue(C_RD,  2'd1, 13'h005, 2'b00, 16'h0, n);
    push_rd(n + 3, 2'b11, 16'hA55A);
    idle(5);

    // Byte mask on write: upper byte of the second write is dropped.
    issue(C_WR, 2'd1, 13'h010, 2'b00, 16'hFFFF, n);
    issue(C_WR, 2'd1, 13'h010, 2'b10, 16'h1234, n);
    issue(C_RD, 2'd1, 13'h010, 2'b00, 16'h0, n);
    push_rd(n + 3, 2'b11, 16'hFF34);
    idle(5);

    // BL4 burst writes: col 6 start wraps 6,7,4,5.
    issue(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0, n);
    issue(C_LMR, 2'd0, 13'h022, 2'b00, 16'h0, n);
    issue(C_ACT, 2'd1, 13'h012, 2'b00, 16'h0, n); idle(1);
    issue(C_WR,  2'd1, 13'h006, 2'b00, 16'h0001, n);
    issue(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0002, n);
    issue(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0003, n);
    issue(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0004, n);
    issue(C_RD,  2'd1, 13'h004, 2'b00, 16'h0, n);
    push_rd(n + 2, 2'b11, 16'h0003); push_rd(n + 3, 2'b11, 16'h0004);
    push_rd(n + 4, 2'b11, 16'h0001); push_rd(n + 5, 2'b11, 16'h0002);
    idle(6);
    // Read starting at the last column of the block wraps 7,4,5,6.
    issue(C_RD, 2'd1, 13'h007, 2'b00, 16'h0, n);
    push_rd(n + 2, 2'b11, 16'h0002); push_rd(n + 3, 2'b11, 16'h0003);
    push_rd(n + 4, 2'b11, 16'h0004); push_rd(n + 5, 2'b11, 16'h0001);
    idle(6);
    // Lower lane masked at READ: oe=10 on every beat.
    issue(C_RD, 2'd1, 13'h004, 2'b01, 16'h0, n);
    push_rd(n + 2, 2'b10, 16'h0003); push_rd(n + 3, 2'b10, 16'h0004);
    push_rd(n + 4, 2'b10, 16'h0001); push_rd(n + 5, 2'b10, 16'h0002);
    idle(6);
    check("burst_err", 32'(err), 32'h0);

    // READ one edge after ACTIVE: timing error, data still returned.
    issue(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0, n);
    issue(C_ACT, 2'd1, 13'h012, 2'b00, 16'h0, n);
    issue(C_RD,  2'd1, 13'h004, 2'b00, 16'h0, n);
    push_rd(n + 2, 2'b11, 16'h0003); push_rd(n + 3, 2'b11, 16'h0004);
    push_rd(n + 4, 2'b11, 16'h0001); push_rd(n + 5, 2'b11, 16'h0002);
    idle(6);
    check("trcd_err", 32'(err), 32'h2);

    // READ on closed bank 2: protocol error, no output.
    issue(C_RD, 2'd2, 13'h000, 2'b00, 16'h0, n);
    for (int i = 0; i < 3; i++) begin
      check("closed_oe", 32'(sd_dq_oe), 32'h0);
      idle(1);
    end
    check("closed_err", 32'(err), 32'h3);

    // BURST_TERMINATE after the first beat leaves only beat 0.
    issue(C_RD,  2'd1, 13'h004, 2'b00, 16'h0, n);
    push_rd(n + 2, 2'b11, 16'h0003);
    issue(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0, n);
    issue(C_BST, 2'd0, 13'h000, 2'b00, 16'h0, n);
    check("bst_oe_drop", 32'(sd_dq_oe), 32'h0);
    idle(4);

    // CL=1 is illegal: err[2], mode stays CL2 BL4.
    issue(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0, n);
    issue(C_LMR, 2'd0, 13'h012, 2'b00, 16'h0, n);
    check("illegal_mode_err", 32'(err), 32'h7);
    issue(C_ACT, 2'd1, 13'h012, 2'b00, 16'h0, n); idle(1);
    issue(C_RD,  2'd1, 13'h005, 2'b00, 16'h0, n);
    push_rd(n + 2, 2'b11, 16'h0004); push_rd(n + 3, 2'b11, 16'h0001);
    push_rd(n + 4, 2'b11, 16'h0002); push_rd(n + 5, 2'b11, 16'h0003);
    idle(6);

    // Bounded drain of any outstanding expectations.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    check("final_refresh", 32'(refresh_cnt), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
